// File: rtl/tcm_lsu_port.sv
// Load/store adapter in front of one TCM RAM port: byte-lane store masks, lane-aligned loads.
// Optional TCM_ALIGN_CHECK_EN makes misaligned half/word accesses fault.
module tcm_lsu_port #(
  parameter int unsigned RAM_AW = 23
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_wr_o,
  input  logic [31:0]       ram_data_i
);

  typedef enum logic [1:0] {StIdle, StResp, StHold} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         hold_q, hold_d;

  logic        req_fault;
  logic        align_fault;
  logic        accept;
  logic        consumed;
  logic [31:0] word;
  logic [31:0] lane_word;
  logic [15:0] half;

  assign resp_valid_o = (state_q != StIdle);
  assign consumed     = resp_valid_o & resp_ready_i;
  assign req_ready_o  = !rst_i && ((state_q == StIdle) || consumed);
  assign accept       = req_valid_i & req_ready_o;

  always_comb begin
    align_fault = 1'b0;
`ifdef TCM_ALIGN_CHECK_EN
    case (req_size_i)
      2'd1:    align_fault = req_addr_i[0];
      2'd2:    align_fault = (req_addr_i[1:0] != 2'b00);
      default: align_fault = 1'b0;
    endcase
`endif
    req_fault = (req_size_i == 2'd3) || ((req_addr_i >> (RAM_AW + 2)) != 32'd0) || align_fault;
  end

  // State register and request/capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      lane_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  state_d = resp_ready_i ? (accept ? StResp : StIdle) : StHold;
      StHold:  if (resp_ready_i) state_d = accept ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lane_d = lane_q;
    size_d = size_q;
    uns_d  = uns_q;
    err_d  = err_q;
    we_d   = we_q;
    addr_d = addr_q;
    hold_d = hold_q;
    if (accept) begin
      lane_d = req_addr_i[1:0];
      size_d = req_size_i;
      uns_d  = req_unsigned_i;
      err_d  = req_fault;
      we_d   = req_we_i;
      addr_d = req_addr_i[RAM_AW+1:2];
    end
    // The RAM read register moves on next cycle, so freeze the word on a stall.
    if (state_q == StResp && !resp_ready_i) hold_d = ram_data_i;
  end

  // Output logic: RAM side.
  always_comb begin
    ram_addr_o = rst_i ? '0 : addr_q;
    ram_data_o = '0;
    ram_wr_o   = '0;
    if (accept) begin
      ram_addr_o = req_addr_i[RAM_AW+1:2];
      case (req_size_i)
        2'd0: begin
          ram_data_o = {4{req_wdata_i[7:0]}};
          ram_wr_o   = 4'b0001 << req_addr_i[1:0];
        end
        2'd1: begin
          ram_data_o = {2{req_wdata_i[15:0]}};
          ram_wr_o   = 4'b0011 << {req_addr_i[1], 1'b0};
        end
        default: begin
          ram_data_o = req_wdata_i;
          ram_wr_o   = 4'b1111;
        end
      endcase
      if (!req_we_i || req_fault) ram_wr_o = '0;
    end
  end

  // Output logic: response side.
  always_comb begin
    word      = (state_q == StHold) ? hold_q : ram_data_i;
    lane_word = word >> {lane_q, 3'b000};
    half      = lane_q[1] ? word[31:16] : word[15:0];
    resp_err_o   = resp_valid_o & err_q;
    resp_rdata_o = '0;
    if (resp_valid_o && !err_q && !we_q) begin
      case (size_q)
        2'd0:    resp_rdata_o = {{24{lane_word[7] & ~uns_q}}, lane_word[7:0]};
        2'd1:    resp_rdata_o = {{16{half[15] & ~uns_q}}, half};
        default: resp_rdata_o = word;
      endcase
    end
  end

endmodule
